spi_cmd_ctrl: RTL and testbench
===============================

Name: spi_cmd_ctrl

Overview:
- Command sequencer between the SPI byte bridge and the PWM register file.
- Turns the bridge's byte stream into register transactions. Byte 0 of a frame is a command; byte 1 is either write data, or a read slot in which the controller supplies data_out.
- Synchronises the bridge's sclk-domain strobes into the peripheral clock and issues one-cycle write and read strobes to the register bank.

Parameters:
- SYNC_STAGES, 2, number of flops in the byte_sync and cs_n synchronisers (minimum 2).
- ADDR_W, 6, register address width taken from command bits [ADDR_W-1:0].
- MAX_ADDR, 6'h0A, highest implemented register address; higher addresses are flagged as errors.

Ports:
- clk  in  1  peripheral clock
- rst_n  in  1  asynchronous active-low reset
- cs_n  in  1  SPI chip select, asynchronous to clk
- byte_sync  in  1  bridge byte-complete flag, asynchronous to clk; data_in is stable while it is high
- data_in  in  8  byte received by the bridge
- data_out  out  8  byte presented to the bridge for miso shifting
- reg_addr  out  ADDR_W  register address
- reg_hi  out  1  high-half select for 16-bit registers (command bit 6)
- reg_wdata  out  8  write data
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  8  register read data, valid 1 cycle after reg_re
- cmd_err  out  1  one-cycle pulse on an illegal address or an aborted frame

Behaviour:
- Reset: all outputs 0; FSM in IDLE; synchronisers cleared.
- byte_sync is synchronised through SYNC_STAGES flops, then rising-edge detected. This gives one internal byte_evt per received byte. data_in is sampled on byte_evt.
- cs_n is synchronised the same way. A synchronised cs_n high forces IDLE from any state.
- Command byte: bit7 = 1 means register read, 0 means register write; bit6 = reg_hi; bits[5:0] = address.
- FSM states:
  - IDLE: on byte_evt with cs_n low, latch addr and hi. If bit7 = 1, go to RD_FETCH; otherwise go to WR_DATA.
  - WR_DATA: wait for the next byte_evt, latch reg_wdata, go to WR_STB.
  - WR_STB: if addr <= MAX_ADDR, pulse reg_we for 1 cycle; otherwise pulse cmd_err instead. Go to IDLE.
  - RD_FETCH: pulse reg_re for 1 cycle if addr <= MAX_ADDR (else pulse cmd_err). Go to RD_LOAD.
  - RD_LOAD: load data_out with reg_rdata, or 8'h00 for an illegal address. Go to RD_HOLD.
  - RD_HOLD: hold data_out stable until the next byte_evt (the read slot completes), then clear data_out to 0 and go to IDLE.
- Latency:
  - Write: reg_we asserts 2 clk after byte_evt of the data byte.
  - Read: data_out is valid 3 clk after byte_evt of the command byte. The bridge begins shifting on the next sclk edge, so SPI_sclk period >= 4 clk is a system requirement.
- Abort: synchronised cs_n rising while in WR_DATA, RD_FETCH, RD_LOAD or RD_HOLD:
  - no reg_we issued;
  - cmd_err pulses once;
  - data_out cleared;
  - return to IDLE.
  - cs_n rising while in IDLE or WR_STB is not an error; a pending WR_STB still completes.
- byte_evt while in WR_STB, RD_FETCH or RD_LOAD is ignored.
- reg_addr, reg_hi and reg_wdata hold their last values between transactions.
- Asynchronous reset mid-frame returns to IDLE immediately; the next byte seen is treated as a command.
- Back-to-back frames: a new command is accepted in IDLE in the cycle immediately following the return to IDLE.

Decomposition:
- Shared package spi_regs_pkg:
  - command bit positions (CMD_RD_BIT = 7, CMD_HI_BIT = 6);
  - FSM state encoding;
  - register address constants and MAX_ADDR.
- One sub-module: sync_pulse, an N-stage synchroniser with rising-edge detect. Instantiate it for byte_sync; instantiate a level-only variant for cs_n.

Test Plan:
- Write: cs_n low, bytes 8'h03 then 8'hA5 -> exactly one reg_we with reg_addr = 3, reg_hi = 0, reg_wdata = A5; cmd_err stays 0.
- High-half read: cs_n low, byte 8'hC2, reg_rdata model returns 8'h5C one cycle after reg_re -> one reg_re with addr = 2, reg_hi = 1; data_out = 5C from 3 clk after byte_evt until the second byte_evt, then 00.
- Illegal address: command 8'h3F then 8'h11 -> no reg_we, one cmd_err pulse. Command 8'hBF -> no reg_re, data_out = 00, one cmd_err.
- Abort: command 8'h04, then cs_n high before the data byte -> no reg_we, one cmd_err, FSM in IDLE; a following frame 8'h04, 8'h22 writes 22 normally.
- Async reset: assert rst_n low while in RD_HOLD -> all outputs 0 immediately; after release, byte 8'h01 is decoded as a command.
- Synchroniser: byte_sync held high for 20 clk -> exactly one byte_evt. Two frames back-to-back with minimum 4-clk sclk -> both writes land in order.

Source files
------------

// File: rtl/spi_regs_pkg.sv
// Shared definitions for the SPI command sequencer: command bit layout,
// FSM states and register map constants.
package spi_regs_pkg;

  localparam int unsigned CMD_RD_BIT = 7;
  localparam int unsigned CMD_HI_BIT = 6;

  localparam logic [5:0] REG_CTRL    = 6'h00;
  localparam logic [5:0] REG_STATUS  = 6'h01;
  localparam logic [5:0] REG_PERIOD  = 6'h02;
  localparam logic [5:0] REG_DUTY0   = 6'h03;
  localparam logic [5:0] REG_DUTY1   = 6'h04;
  localparam logic [5:0] REG_DUTY2   = 6'h05;
  localparam logic [5:0] REG_DUTY3   = 6'h06;
  localparam logic [5:0] REG_PRESCL  = 6'h07;
  localparam logic [5:0] REG_DEADT   = 6'h08;
  localparam logic [5:0] REG_IRQEN   = 6'h09;
  localparam logic [5:0] REG_IRQST   = 6'h0A;
  localparam logic [5:0] MAX_ADDR    = REG_IRQST;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_WR_STB,
    ST_RD_FETCH,
    ST_RD_LOAD,
    ST_RD_HOLD
  } state_e;

endpackage

// File: rtl/sync_pulse.sv
// N-stage synchroniser; EDGE_DET=1 yields a one-cycle rising-edge pulse,
// EDGE_DET=0 yields the synchronised level.
module sync_pulse #(
  parameter int unsigned STAGES   = 2,
  parameter bit          EDGE_DET = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  generate
    if (EDGE_DET) begin : g_edge
      logic r_prev;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_prev <= 1'b0;
        else        r_prev <= r_sync[STAGES-1];
      end
      assign o_q = r_sync[STAGES-1] & ~r_prev;
    end else begin : g_level
      assign o_q = r_sync[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Command sequencer: decodes SPI command/data byte pairs from the bridge into
// one-cycle register write/read strobes and supplies read data for miso.
module spi_cmd_ctrl
  import spi_regs_pkg::*;
#(
  parameter int unsigned       SYNC_STAGES = 2,
  parameter int unsigned       ADDR_W      = 6,
  parameter logic [ADDR_W-1:0] MAX_ADDR    = ADDR_W'(spi_regs_pkg::MAX_ADDR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              byte_sync,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_hi,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              cmd_err
);

  logic w_byte_evt;
  logic w_cs_sync;

  sync_pulse #(.STAGES(SYNC_STAGES), .EDGE_DET(1'b1)) u_byte_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (byte_sync),
    .o_q   (w_byte_evt)
  );

  sync_pulse #(.STAGES(SYNC_STAGES), .EDGE_DET(1'b0)) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (cs_n),
    .o_q   (w_cs_sync)
  );

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr,  w_addr_nxt;
  logic              r_hi,    w_hi_nxt;
  logic [7:0]        r_wdata, w_wdata_nxt;
  logic [7:0]        r_dout,  w_dout_nxt;
  logic              r_we,    w_we_nxt;
  logic              r_re,    w_re_nxt;
  logic              r_err,   w_err_nxt;
  logic              w_cmd_legal;
  logic              w_addr_legal;

  assign w_cmd_legal  = (data_in[ADDR_W-1:0] <= MAX_ADDR);
  assign w_addr_legal = (r_addr <= MAX_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_hi    <= 1'b0;
      r_wdata <= '0;
      r_dout  <= '0;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_hi    <= w_hi_nxt;
      r_wdata <= w_wdata_nxt;
      r_dout  <= w_dout_nxt;
      r_we    <= w_we_nxt;
      r_re    <= w_re_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Strobes are registered: the read strobe is launched on the command byte so
  // it is visible during RD_FETCH, letting RD_LOAD capture reg_rdata a cycle later.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_hi_nxt    = r_hi;
    w_wdata_nxt = r_wdata;
    w_dout_nxt  = r_dout;
    w_we_nxt    = 1'b0;
    w_re_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_byte_evt && !w_cs_sync) begin
          w_addr_nxt = data_in[ADDR_W-1:0];
          w_hi_nxt   = data_in[CMD_HI_BIT];
          if (data_in[CMD_RD_BIT]) begin
            w_re_nxt    = w_cmd_legal;
            w_err_nxt   = !w_cmd_legal;
            w_state_nxt = ST_RD_FETCH;
          end else begin
            w_state_nxt = ST_WR_DATA;
          end
        end
      end
      ST_WR_DATA: begin
        if (w_cs_sync) begin
          w_err_nxt   = 1'b1;
          w_dout_nxt  = '0;
          w_state_nxt = ST_IDLE;
        end else if (w_byte_evt) begin
          w_wdata_nxt = data_in;
          w_state_nxt = ST_WR_STB;
        end
      end
      ST_WR_STB: begin
        w_we_nxt    = w_addr_legal;
        w_err_nxt   = !w_addr_legal;
        w_state_nxt = ST_IDLE;
      end
      ST_RD_FETCH: begin
        if (w_cs_sync) begin
          w_err_nxt   = 1'b1;
          w_dout_nxt  = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RD_LOAD;
        end
      end
      ST_RD_LOAD: begin
        if (w_cs_sync) begin
          w_err_nxt   = 1'b1;
          w_dout_nxt  = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_dout_nxt  = w_addr_legal ? reg_rdata : 8'h00;
          w_state_nxt = ST_RD_HOLD;
        end
      end
      ST_RD_HOLD: begin
        if (w_cs_sync) begin
          w_err_nxt   = 1'b1;
          w_dout_nxt  = '0;
          w_state_nxt = ST_IDLE;
        end else if (w_byte_evt) begin
          w_dout_nxt  = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign data_out  = r_dout;
  assign reg_addr  = r_addr;
  assign reg_hi    = r_hi;
  assign reg_wdata = r_wdata;
  assign reg_we    = r_we;
  assign reg_re    = r_re;
  assign cmd_err   = r_err;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Scoreboard bench for spi_cmd_ctrl: stimulus queues expected register
// transactions, a negedge monitor pops and compares them as the DUT emits them.
module tb_spi_cmd_ctrl;

  localparam int K_WE   = 1;
  localparam int K_RE   = 2;
  localparam int K_ERR  = 3;
  localparam int K_DOUT = 4;

  typedef struct {
    int         kind;
    logic [5:0] addr;
    logic       hi;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs_n;
  logic       byte_sync;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [5:0] reg_addr;
  logic       reg_hi;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       cmd_err;

  int   checks   = 0;
  int   failures = 0;
  bit   done     = 1'b0;
  exp_t sb[$];

  spi_cmd_ctrl #(.SYNC_STAGES(2), .ADDR_W(6), .MAX_ADDR(6'h0A)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs_n      (cs_n),
    .byte_sync (byte_sync),
    .data_in   (data_in),
    .data_out  (data_out),
    .reg_addr  (reg_addr),
    .reg_hi    (reg_hi),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  // Register bank read model: data one cycle after reg_re.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) reg_rdata <= 8'h00;
    else if (reg_re) reg_rdata <= (reg_addr == 6'd2 && reg_hi) ? 8'h5C : {2'b10, reg_addr};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input logic [5:0] addr, input logic hi, input logic [7:0] data);
    exp_t e;
    e.kind = kind; e.addr = addr; e.hi = hi; e.data = data;
    sb.push_back(e);
  endtask

  // One byte at the minimum sclk pacing: 2 clk high, 2 clk low.
  task automatic send_byte(input logic [7:0] b);
    data_in   = b;
    byte_sync = 1'b1;
    tick(2);
    byte_sync = 1'b0;
    tick(2);
  endtask

  function automatic logic [31:0] pack(input int kind, input logic [5:0] addr, input logic hi, input logic [7:0] data);
    return {8'(kind), 7'd0, hi, 2'd0, addr, data};
  endfunction

  task automatic sb_check(input string name, input int kind, input logic [5:0] addr, input logic hi, input logic [7:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: unexpected event actual=%h required=none", name, pack(kind, addr, hi, data));
    end else begin
      e = sb.pop_front();
      chk(name, pack(kind, addr, hi, data), pack(e.kind, e.addr, e.hi, e.data));
    end
  endtask

  initial begin : monitor
    logic [7:0] prev_dout;
    prev_dout = 8'h00;
    while (!done) begin
      @(negedge clk);
      if (reg_we)  sb_check("reg_we",  K_WE,  reg_addr, reg_hi, reg_wdata);
      if (reg_re)  sb_check("reg_re",  K_RE,  reg_addr, reg_hi, 8'h00);
      if (cmd_err) sb_check("cmd_err", K_ERR, 6'd0, 1'b0, 8'h00);
      if (data_out !== prev_dout) sb_check("data_out", K_DOUT, 6'd0, 1'b0, data_out);
      prev_dout = data_out;
    end
  end

  initial begin : stimulus
    rst_n     = 1'b0;
    cs_n      = 1'b1;
    byte_sync = 1'b0;
    data_in   = 8'h00;
    tick(2);
    chk("rst_data_out",  32'(data_out),  32'h0);
    chk("rst_reg_addr",  32'(reg_addr),  32'h0);
    chk("rst_reg_hi",    32'(reg_hi),    32'h0);
    chk("rst_reg_wdata", 32'(reg_wdata), 32'h0);
    chk("rst_reg_we",    32'(reg_we),    32'h0);
    chk("rst_reg_re",    32'(reg_re),    32'h0);
    chk("rst_cmd_err",   32'(cmd_err),   32'h0);
    rst_n = 1'b1;
    tick(2);

    // Write 03 <- A5 with latency check on reg_we.
    cs_n = 1'b0;
    tick(3);
    push(K_WE, 6'd3, 1'b0, 8'hA5);
    send_byte(8'h03);
    data_in   = 8'hA5;
    byte_sync = 1'b1;
    tick(3);
    chk("wr_lat_early", 32'(reg_we), 32'h0);
    tick(1);
    chk("wr_lat_we", 32'(reg_we), 32'h1);
    byte_sync = 1'b0;
    tick(2);
    cs_n = 1'b1;
    tick(4);

    // High-half read of address 2.
    cs_n = 1'b0;
    tick(3);
    push(K_RE, 6'd2, 1'b1, 8'h00);
    push(K_DOUT, 6'd0, 1'b0, 8'h5C);
    push(K_DOUT, 6'd0, 1'b0, 8'h00);
    data_in   = 8'hC2;
    byte_sync = 1'b1;
    tick(4);
    chk("rd_lat_early", 32'(data_out), 32'h00);
    tick(1);
    chk("rd_lat_valid", 32'(data_out), 32'h5C);
    byte_sync = 1'b0;
    tick(2);
    data_in   = 8'h00;
    byte_sync = 1'b1;
    tick(2);
    chk("rd_hold", 32'(data_out), 32'h5C);
    tick(1);
    chk("rd_clear", 32'(data_out), 32'h00);
    byte_sync = 1'b0;
    tick(2);

    // Illegal write and illegal read.
    push(K_ERR, 6'd0, 1'b0, 8'h00);
    send_byte(8'h3F);
    send_byte(8'h11);
    tick(2);
    push(K_ERR, 6'd0, 1'b0, 8'h00);
    send_byte(8'hBF);
    tick(2);
    chk("rd_illegal_dout", 32'(data_out), 32'h00);
    send_byte(8'h00);
    tick(2);

    // Abort mid-frame, then a clean frame to the same address.
    push(K_ERR, 6'd0, 1'b0, 8'h00);
    send_byte(8'h04);
    cs_n = 1'b1;
    tick(4);
    cs_n = 1'b0;
    tick(3);
    push(K_WE, 6'd4, 1'b0, 8'h22);
    send_byte(8'h04);
    send_byte(8'h22);
    tick(2);

    // byte_sync held high for 20 clk must count as one byte.
    push(K_WE, 6'd5, 1'b0, 8'h77);
    data_in   = 8'h05;
    byte_sync = 1'b1;
    tick(20);
    byte_sync = 1'b0;
    tick(2);
    send_byte(8'h77);
    tick(2);

    // Back-to-back frames at minimum sclk pacing.
    push(K_WE, 6'd1, 1'b0, 8'h11);
    push(K_WE, 6'd2, 1'b0, 8'h22);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h02);
    send_byte(8'h22);
    tick(3);

    // Asynchronous reset while holding read data.
    push(K_RE, 6'd2, 1'b1, 8'h00);
    push(K_DOUT, 6'd0, 1'b0, 8'h5C);
    push(K_DOUT, 6'd0, 1'b0, 8'h00);
    data_in   = 8'hC2;
    byte_sync = 1'b1;
    tick(5);
    byte_sync = 1'b0;
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_data_out", 32'(data_out), 32'h0);
    chk("arst_reg_addr", 32'(reg_addr), 32'h0);
    chk("arst_reg_hi",   32'(reg_hi),   32'h0);
    chk("arst_reg_we",   32'(reg_we),   32'h0);
    chk("arst_cmd_err",  32'(cmd_err),  32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    push(K_WE, 6'd1, 1'b0, 8'h33);
    send_byte(8'h01);
    send_byte(8'h33);
    tick(5);

    done = 1'b1;
    tick(3);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_event: actual=none required=%h", pack(e.kind, e.addr, e.hi, e.data));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
